// File: rtl/mem_region_decoder.sv
// Registered address decoder between a valid/ready CPU port and N memory-mapped regions.
// Each region has its own base, size, wait states and read-only flag; misses and RO writes return a bus error.
module mem_region_decoder #(
  parameter int unsigned N_REGIONS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE = '0,
  parameter logic [N_REGIONS*4-1:0]      REGION_WAIT = '0,
  parameter logic [N_REGIONS-1:0]        REGION_RO   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_valid,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  input  logic [DATA_W/8-1:0]           cpu_wstrb,
  output logic                          cpu_ready,
  output logic                          cpu_err,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic [N_REGIONS-1:0]          reg_sel,
  output logic [ADDR_W-3:0]             reg_offset,
  output logic [DATA_W-1:0]             reg_wdata,
  output logic [DATA_W/8-1:0]           reg_wstrb,
  input  logic [N_REGIONS*DATA_W-1:0]   reg_rdata
);

  localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned OFF_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [OFF_W-1:0] hit_off;
  logic [3:0]       hit_wait;
  logic             hit_ro;
  logic [ADDR_W-1:0] diff;
  logic             is_write;

  assign is_write = |cpu_wstrb;

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_off  = '0;
    hit_wait = '0;
    hit_ro   = 1'b0;
    diff     = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      diff = cpu_addr - REGION_BASE[i*ADDR_W +: ADDR_W];
      if ((REGION_SIZE[i*ADDR_W +: ADDR_W] != '0) &&
          (cpu_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
          (diff < REGION_SIZE[i*ADDR_W +: ADDR_W])) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_off  = OFF_W'(diff >> 2);
        hit_wait = REGION_WAIT[i*4 +: 4];
        hit_ro   = REGION_RO[i];
      end
    end
  end

  // Transaction FSM; reg_wstrb doubles as the latched read/write indicator during ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      cpu_ready  <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      reg_sel    <= '0;
      reg_offset <= '0;
      reg_wdata  <= '0;
      reg_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_valid) begin
            if (hit && (!is_write || !hit_ro)) begin
              state      <= ACCESS;
              idx        <= hit_idx;
              cnt        <= hit_wait;
              reg_sel    <= N_REGIONS'(1) << hit_idx;
              reg_offset <= hit_off;
              reg_wdata  <= cpu_wdata;
              reg_wstrb  <= cpu_wstrb;
            end else begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (reg_wstrb == '0) begin
              cpu_rdata <= reg_rdata[idx*DATA_W +: DATA_W];
            end
            reg_sel   <= '0;
            reg_wstrb <= '0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_region_decoder.sv
// Scoreboard bench for mem_region_decoder: expectations queued at request time, checked as the DUT responds.
module tb_mem_region_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_valid;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_wstrb;
  logic         cpu_ready;
  logic         cpu_err;
  logic [31:0]  cpu_rdata;
  logic [3:0]   reg_sel;
  logic [29:0]  reg_offset;
  logic [31:0]  reg_wdata;
  logic [3:0]   reg_wstrb;
  logic [127:0] reg_rdata;

  // Regions: 0 ROM 0x0/1K RO W0, 1 RAM 0x400/6K W2, 2 top 0xFFFFF000/4K W1, 3 overlap 0x400/16 W0
  mem_region_decoder #(
    .N_REGIONS  (4),
    .ADDR_W     (32),
    .DATA_W     (32),
    .REGION_BASE({32'h0000_0400, 32'hFFFF_F000, 32'h0000_0400, 32'h0000_0000}),
    .REGION_SIZE({32'h0000_0010, 32'h0000_1000, 32'h0000_1800, 32'h0000_0400}),
    .REGION_WAIT({4'd0, 4'd1, 4'd2, 4'd0}),
    .REGION_RO  (4'b0001)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .reg_sel   (reg_sel),
    .reg_offset(reg_offset),
    .reg_wdata (reg_wdata),
    .reg_wstrb (reg_wstrb),
    .reg_rdata (reg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [29:0] off;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    bit          b2b;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          nsel = 0;
  int          since_ready = 0;
  logic [31:0] last_rdata = '0;

  function automatic logic [31:0] region_data(input int r);
    case (r)
      0:       return 32'hDEAD_0000;
      1:       return 32'h1234_5678;
      2:       return 32'hFFFF_0002;
      default: return 32'h3333_3333;
    endcase
  endfunction

  function automatic int wait_of(input int r);
    case (r)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request (r < 0 means a bus error is expected) and wait for its completion.
  task automatic req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     input int r, input logic [29:0] off, input bit b2b);
    exp_t e;
    int   n;
    int   lat;
    e.r = r; e.off = off; e.strb = s; e.wdata = d; e.err = (r < 0); e.b2b = b2b;
    if (r < 0)        e.rdata = '0;
    else if (s != '0) e.rdata = last_rdata;
    else              e.rdata = region_data(r);
    last_rdata = e.rdata;
    lat = ((r < 0) ? 1 : wait_of(r) + 2) + (b2b ? 1 : 0);
    q.push_back(e);
    cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = s; cpu_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 40);
    chk("latency", 64'(n), 64'(lat));
  endtask

  task automatic idle();
    cpu_valid = 1'b0;
    cpu_wstrb = '0;
    @(negedge clk);
  endtask

  // Monitor: per-cycle select checks and completion checks against the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      q.delete();
      nsel = 0;
      since_ready = 0;
    end else begin
      since_ready++;
      if (reg_sel != '0) begin
        if (q.size() == 0) begin
          chk("spurious_sel", 64'(reg_sel), 64'(0));
        end else begin
          e = q[0];
          chk("sel", 64'(reg_sel), (e.r < 0) ? 64'(0) : (64'(1) << e.r));
          if (nsel == 0) begin
            chk("offset", 64'(reg_offset), 64'(e.off));
            chk("wstrb", 64'(reg_wstrb), 64'(e.strb));
            if (e.strb != '0) chk("wdata", 64'(reg_wdata), 64'(e.wdata));
            if (e.b2b) chk("b2b_gap", 64'(since_ready), 64'(2));
          end
          nsel++;
        end
      end
      if (cpu_ready) begin
        if (q.size() == 0) begin
          chk("spurious_ready", 64'(cpu_ready), 64'(0));
        end else begin
          e = q.pop_front();
          chk("err", 64'(cpu_err), 64'(e.err));
          chk("rdata", 64'(cpu_rdata), 64'(e.rdata));
          chk("sel_cycles", 64'(nsel), (e.r < 0) ? 64'(0) : 64'(wait_of(e.r) + 1));
        end
        nsel = 0;
        since_ready = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    reg_rdata = {32'h3333_3333, 32'hFFFF_0002, 32'h1234_5678, 32'hDEAD_0000};
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 64'(cpu_ready), 64'(0));
    chk("rst_err", 64'(cpu_err), 64'(0));
    chk("rst_sel", 64'(reg_sel), 64'(0));
    chk("rst_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_offset", 64'(reg_offset), 64'(0));
    chk("rst_wstrb", 64'(reg_wstrb), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    req(32'h0000_0404, 4'h0, '0, 1, 30'h1, 1'b0);            idle();
    req(32'h0000_03FC, 4'h0, '0, 0, 30'hFF, 1'b0);           idle();
    req(32'h0000_0010, 4'hF, 32'hAAAA_5555, -1, '0, 1'b0);   idle();
    req(32'h0000_2000, 4'h0, '0, -1, '0, 1'b0);              idle();
    req(32'h0000_1BFC, 4'h0, '0, 1, 30'h5FF, 1'b0);          idle();
    req(32'h0000_1C00, 4'h0, '0, -1, '0, 1'b0);              idle();
    req(32'hFFFF_FFFC, 4'h0, '0, 2, 30'h3FF, 1'b0);          idle();
    req(32'h0000_0408, 4'h3, 32'hCAFE_BABE, 1, 30'h2, 1'b0); idle();
    req(32'hFFFF_F004, 4'hC, 32'h0BAD_F00D, 2, 30'h1, 1'b0); idle();

    // Held cpu_valid across completions
    req(32'h0000_0404, 4'h0, '0, 1, 30'h1, 1'b0);
    req(32'h0000_0000, 4'h0, '0, 0, 30'h0, 1'b1);
    req(32'h0000_1000, 4'h0, '0, 1, 30'h300, 1'b1);          idle();

    // Reset asserted while the access is in flight
    begin
      exp_t e;
      e.r = 1; e.off = 30'h1; e.strb = '0; e.wdata = '0; e.rdata = '0; e.err = 1'b0; e.b2b = 1'b0;
      q.push_back(e);
      cpu_valid = 1'b1; cpu_addr = 32'h0000_0404; cpu_wstrb = '0;
      @(negedge clk); @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_sel", 64'(reg_sel), 64'(0));
      chk("abort_ready", 64'(cpu_ready), 64'(0));
      chk("abort_rdata", 64'(cpu_rdata), 64'(0));
      chk("abort_offset", 64'(reg_offset), 64'(0));
      cpu_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("abort_no_ready", 64'(cpu_ready), 64'(0));
      end
      rst = 1'b0;
      last_rdata = '0;
      @(negedge clk);
    end

    req(32'h0000_0408, 4'h0, '0, 1, 30'h2, 1'b0);            idle();
    req(32'h0000_0010, 4'h0, '0, 0, 30'h4, 1'b0);            idle();
    @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
